// File: rtl/bm_dz_replay_buffer.sv
// Two-slot ping-pong row buffer: captures dz rows with their max/min lane flags and
// replays each row as a gapless burst once the reduction releases its scalars.
module bm_dz_replay_buffer #(
  parameter int bitwidth   = 16,
  parameter int N          = 8,
  parameter int hidden_num = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*bitwidth-1:0] in_dz,
  input  logic [N-1:0]          in_max_index,
  input  logic [N-1:0]          in_min_index,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  release_valid,
  output logic [N*bitwidth-1:0] dz,
  output logic [N-1:0]          max_index,
  output logic [N-1:0]          min_index,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  len_err,
  output logic                  rel_err
);
  localparam int BEATS = hidden_num / N;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam int DW    = N * bitwidth;

  typedef enum logic {IDLE, PLAY} state_t;

  logic [DW-1:0] dz_mem_q  [2][BEATS];
  logic [N-1:0]  max_mem_q [2][BEATS];
  logic [N-1:0]  min_mem_q [2][BEATS];

  state_t        state_q, state_d;
  logic          wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [BW-1:0] wr_beat_q, wr_beat_d, rd_beat_q, rd_beat_d;
  logic [1:0]    count_q, count_d, pend_q, pend_d;
  logic [DW-1:0] dz_q, dz_d;
  logic [N-1:0]  max_q, max_d, min_q, min_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          len_err_q, len_err_d, rel_err_q, rel_err_d;

  logic          accept, commit, load, done;
  logic [BW-1:0] load_beat;

  assign in_ready  = !rst && (count_q < 2'd2);
  assign dz        = dz_q;
  assign max_index = max_q;
  assign min_index = min_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign len_err   = len_err_q;
  assign rel_err   = rel_err_q;

  always_comb begin
    wr_slot_d   = wr_slot_q;
    wr_beat_d   = wr_beat_q;
    rd_slot_d   = rd_slot_q;
    rd_beat_d   = rd_beat_q;
    count_d     = count_q;
    pend_d      = pend_q;
    state_d     = state_q;
    dz_d        = dz_q;
    max_d       = max_q;
    min_d       = min_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    len_err_d   = len_err_q;
    rel_err_d   = rel_err_q;
    load        = 1'b0;
    done        = 1'b0;
    load_beat   = rd_beat_q;

    // Capture: framing is by beat count; in_last is only cross-checked.
    accept = in_valid && in_ready;
    commit = accept && (wr_beat_q == LAST_BEAT);
    if (accept) begin
      if (in_last != (wr_beat_q == LAST_BEAT)) len_err_d = 1'b1;
      if (commit) begin
        wr_beat_d = '0;
        wr_slot_d = ~wr_slot_q;
      end else begin
        wr_beat_d = wr_beat_q + BW'(1);
      end
    end

    case (state_q)
      IDLE: if (count_q != 2'd0 && pend_q != 2'd0) begin
        load      = 1'b1;
        load_beat = '0;
      end
      PLAY: load = 1'b1;
      default: ;
    endcase

    if (load) begin
      dz_d        = dz_mem_q[rd_slot_q][load_beat];
      max_d       = max_mem_q[rd_slot_q][load_beat];
      min_d       = min_mem_q[rd_slot_q][load_beat];
      out_valid_d = 1'b1;
      out_last_d  = (load_beat == LAST_BEAT);
      if (load_beat == LAST_BEAT) begin
        done      = 1'b1;
        rd_beat_d = '0;
        rd_slot_d = ~rd_slot_q;
      end else begin
        rd_beat_d = load_beat + BW'(1);
      end
    end

    case ({commit, done})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: ;
    endcase

    // A release coinciding with a completed row leaves pend unchanged.
    if (release_valid && !done) begin
      if (pend_q == 2'd2) rel_err_d = 1'b1;
      else                pend_d    = pend_q + 2'd1;
    end else if (!release_valid && done) begin
      pend_d = pend_q - 2'd1;
    end

    if (done)      state_d = (count_d != 2'd0 && pend_d != 2'd0) ? PLAY : IDLE;
    else if (load) state_d = PLAY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_slot_q   <= 1'b0;
      wr_beat_q   <= '0;
      rd_slot_q   <= 1'b0;
      rd_beat_q   <= '0;
      count_q     <= 2'd0;
      pend_q      <= 2'd0;
      dz_q        <= '0;
      max_q       <= '0;
      min_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      len_err_q   <= 1'b0;
      rel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_slot_q   <= wr_slot_d;
      wr_beat_q   <= wr_beat_d;
      rd_slot_q   <= rd_slot_d;
      rd_beat_q   <= rd_beat_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      dz_q        <= dz_d;
      max_q       <= max_d;
      min_q       <= min_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      len_err_q   <= len_err_d;
      rel_err_q   <= rel_err_d;
    end
  end

  // Row storage holds only data, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dz_mem_q[wr_slot_q][wr_beat_q]  <= in_dz;
      max_mem_q[wr_slot_q][wr_beat_q] <= in_max_index;
      min_mem_q[wr_slot_q][wr_beat_q] <= in_min_index;
    end
  end

endmodule

// File: tb/tb_bm_dz_replay_buffer.sv
// Directed bench for bm_dz_replay_buffer at default sizes (two beats per row).
module tb_bm_dz_replay_buffer;
  localparam int BWD = 16;
  localparam int NL  = 8;
  localparam int HN  = 16;
  localparam int DW  = NL * BWD;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_dz;
  logic [NL-1:0] in_max_index, in_min_index;
  logic          in_valid, in_last, in_ready, release_valid;
  logic [DW-1:0] dz;
  logic [NL-1:0] max_index, min_index;
  logic          out_valid, out_last, len_err, rel_err;

  int checks = 0;
  int errors = 0;

  bm_dz_replay_buffer #(.bitwidth(BWD), .N(NL), .hidden_num(HN)) dut (
    .clk(clk), .rst(rst),
    .in_dz(in_dz), .in_max_index(in_max_index), .in_min_index(in_min_index),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .release_valid(release_valid),
    .dz(dz), .max_index(max_index), .min_index(min_index),
    .out_valid(out_valid), .out_last(out_last),
    .len_err(len_err), .rel_err(rel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dval(int r, int b);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) v[i*BWD +: BWD] = BWD'(r * 256 + b * 16 + i);
    return v;
  endfunction

  function automatic logic [NL-1:0] mxv(int r, int b);
    return NL'(r * 37 + b * 5 + 1);
  endfunction

  function automatic logic [NL-1:0] mnv(int r, int b);
    return NL'(r * 19 + b * 11 + 2);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int r, input int b, input logic last);
    in_valid     = 1'b1;
    in_dz        = dval(r, b);
    in_max_index = mxv(r, b);
    in_min_index = mnv(r, b);
    in_last      = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int r, input int b, input logic last);
    check({tag, "_valid"}, DW'(out_valid), DW'(1'b1));
    check({tag, "_dz"},    dz, dval(r, b));
    check({tag, "_max"},   DW'(max_index), DW'(mxv(r, b)));
    check({tag, "_min"},   DW'(min_index), DW'(mnv(r, b)));
    check({tag, "_last"},  DW'(out_last), DW'(last));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, DW'(out_valid), '0);
    check({tag, "_last"},  DW'(out_last), '0);
  endtask

  initial begin
    rst = 1'b1;
    in_dz = '0; in_max_index = '0; in_min_index = '0;
    in_valid = 1'b0; in_last = 1'b0; release_valid = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", DW'(in_ready), '0);
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_dz", dz, '0);
    check("rst_len_err", DW'(len_err), '0);
    check("rst_rel_err", DW'(rel_err), '0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", DW'(in_ready), DW'(1'b1));

    // Row A captured, release three cycles later
    drive_beat(1, 0, 1'b0); tick();
    drive_beat(1, 1, 1'b1); tick();
    idle_in(); tick(); tick();
    release_valid = 1'b1; tick();
    release_valid = 1'b0;
    check_quiet("a_wait");
    tick(); check_beat("a0", 1, 0, 1'b0);
    tick(); check_beat("a1", 1, 1, 1'b1);
    tick(); check_quiet("a_end");
    check("a_len_err", DW'(len_err), '0);

    // Release arrives before the row commits
    release_valid = 1'b1; tick();
    release_valid = 1'b0;
    drive_beat(2, 0, 1'b0); tick();
    drive_beat(2, 1, 1'b1); tick();
    idle_in();
    check_quiet("b_commit");
    tick(); check_beat("b0", 2, 0, 1'b0);
    tick(); check_beat("b1", 2, 1, 1'b1);
    tick(); check_quiet("b_end");

    // Two rows fill both slots, a third stalls, then gapless replay
    drive_beat(3, 0, 1'b0); tick();
    drive_beat(3, 1, 1'b1); tick();
    drive_beat(4, 0, 1'b0); tick();
    drive_beat(4, 1, 1'b1); tick();
    check("c_full_in_ready", DW'(in_ready), '0);
    drive_beat(5, 0, 1'b0);
    release_valid = 1'b1; tick();
    check("c_stall_in_ready", DW'(in_ready), '0);
    tick();
    release_valid = 1'b0;
    check_beat("c0", 3, 0, 1'b0);
    check("c0_in_ready", DW'(in_ready), '0);
    tick();
    check_beat("c1", 3, 1, 1'b1);
    check("c1_in_ready", DW'(in_ready), DW'(1'b1));
    idle_in();
    tick(); check_beat("d0", 4, 0, 1'b0);
    tick(); check_beat("d1", 4, 1, 1'b1);
    tick(); check_quiet("d_end");

    // Release overflow, then two rows consume the saturated count
    release_valid = 1'b1; tick();
    tick();
    check("ovf_rel_err_2", DW'(rel_err), '0);
    tick();
    release_valid = 1'b0;
    check("ovf_rel_err_3", DW'(rel_err), DW'(1'b1));
    drive_beat(6, 0, 1'b0); tick();
    drive_beat(6, 1, 1'b1); tick();
    check_quiet("f_commit");
    drive_beat(7, 0, 1'b0); tick();
    check_beat("f0", 6, 0, 1'b0);
    drive_beat(7, 1, 1'b1); tick();
    check_beat("f1", 6, 1, 1'b1);
    idle_in();
    tick(); check_beat("g0", 7, 0, 1'b0);
    tick(); check_beat("g1", 7, 1, 1'b1);
    tick(); check_quiet("g_end");
    tick(); tick();
    check_quiet("stale_release");
    check("ovf_rel_err_sticky", DW'(rel_err), DW'(1'b1));

    // Misplaced in_last: error flagged, row still framed by count
    drive_beat(8, 0, 1'b1); tick();
    check("h_len_err", DW'(len_err), DW'(1'b1));
    drive_beat(8, 1, 1'b1); tick();
    idle_in();
    check("h_len_err_sticky", DW'(len_err), DW'(1'b1));
    release_valid = 1'b1; tick();
    release_valid = 1'b0;
    tick(); check_beat("h0", 8, 0, 1'b0);
    tick(); check_beat("h1", 8, 1, 1'b1);
    tick(); check_quiet("h_end");

    // Reset during playback discards everything buffered
    drive_beat(9, 0, 1'b0);  tick();
    drive_beat(9, 1, 1'b1);  tick();
    drive_beat(10, 0, 1'b0); tick();
    drive_beat(10, 1, 1'b1); tick();
    idle_in();
    release_valid = 1'b1; tick();
    tick();
    release_valid = 1'b0;
    check_beat("j0", 9, 0, 1'b0);
    tick();
    check_beat("j1", 9, 1, 1'b1);
    rst = 1'b1; tick();
    check("mid_rst_out_valid", DW'(out_valid), '0);
    check("mid_rst_in_ready", DW'(in_ready), '0);
    check("mid_rst_dz", dz, '0);
    check("mid_rst_len_err", DW'(len_err), '0);
    check("mid_rst_rel_err", DW'(rel_err), '0);
    rst = 1'b0; tick();
    check("after_rst_in_ready", DW'(in_ready), DW'(1'b1));
    check_quiet("after_rst_1");
    tick(); tick();
    check_quiet("after_rst_3");

    // Normal operation after the reset
    drive_beat(11, 0, 1'b0); tick();
    drive_beat(11, 1, 1'b1); tick();
    idle_in();
    release_valid = 1'b1; tick();
    release_valid = 1'b0;
    check_quiet("l_wait");
    tick(); check_beat("l0", 11, 0, 1'b0);
    tick(); check_beat("l1", 11, 1, 1'b1);
    tick(); check_quiet("l_end");
    check("l_len_err", DW'(len_err), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
